// File: rtl/status_monitor.sv
// Status monitor: queues processor status codes in a FWFT FIFO, counts R/I-type codes,
// and stops accepting on overflow/EOF. Optional RUN cycle counter: STATUS_MONITOR_CYCLE_CNT_EN.
module status_monitor #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [1:0]       i_status,
  input  logic             i_status_valid,
  output logic [1:0]       o_out_status,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [CNT_W-1:0] o_r_cnt,
  output logic [CNT_W-1:0] o_i_cnt,
  output logic             o_done,
  output logic [1:0]       o_cause,
  output logic             o_drop,
  output logic [CNT_W-1:0] o_cycle_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PW:0]       count_q, count_d;
  logic [CNT_W-1:0]  r_cnt_q, i_cnt_q;
  logic [1:0]        cause_q;
  logic              drop_q;

  logic accept, pop, full, push;

  assign accept = (state_q == RUN) && i_status_valid;
  assign full   = (count_q == FULL_CNT);
  assign pop    = (count_q != '0) && i_out_ready;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign push   = accept && (!full || pop);

  always_comb begin
    count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    state_d = state_q;
    case (state_q)
      RUN:     if (accept && i_status[1]) state_d = DRAIN;
      DRAIN:   if (count_d == '0) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= RUN;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      r_cnt_q  <= '0;
      i_cnt_q  <= '0;
      cause_q  <= 2'd0;
      drop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (accept && !push) drop_q <= 1'b1;
      if (accept && i_status == 2'd0 && r_cnt_q != '1) r_cnt_q <= r_cnt_q + 1'b1;
      if (accept && i_status == 2'd1 && i_cnt_q != '1) i_cnt_q <= i_cnt_q + 1'b1;
      if (accept && i_status[1]) cause_q <= i_status;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_status;
  end

  assign o_out_valid  = (count_q != '0);
  assign o_out_status = o_out_valid ? mem_q[rd_ptr_q] : 2'd0;
  assign o_r_cnt      = r_cnt_q;
  assign o_i_cnt      = i_cnt_q;
  assign o_done       = (state_q == DONE);
  assign o_cause      = cause_q;
  assign o_drop       = drop_q;

`ifdef STATUS_MONITOR_CYCLE_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cycle_cnt_q <= '0;
    end else if (state_q == RUN && cycle_cnt_q != '1) begin
      cycle_cnt_q <= cycle_cnt_q + 1'b1;
    end
  end

  assign o_cycle_cnt = cycle_cnt_q;
`else
  assign o_cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_status_monitor.sv
// Directed bench for status_monitor (FIFO_DEPTH=4, CNT_W=16) with hand-computed expectations.
module tb_status_monitor;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [1:0]  i_status = 2'd0;
  logic        i_status_valid = 1'b0;
  logic [1:0]  o_out_status;
  logic        o_out_valid;
  logic        i_out_ready = 1'b0;
  logic [15:0] o_r_cnt, o_i_cnt, o_cycle_cnt;
  logic        o_done, o_drop;
  logic [1:0]  o_cause;

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  status_monitor #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_status(i_status), .i_status_valid(i_status_valid),
    .o_out_status(o_out_status), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_r_cnt(o_r_cnt), .o_i_cnt(o_i_cnt), .o_done(o_done), .o_cause(o_cause),
    .o_drop(o_drop), .o_cycle_cnt(o_cycle_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push(input logic [1:0] code);
    i_status = code;
    i_status_valid = 1'b1;
    cycle();
    i_status_valid = 1'b0;
  endtask

  task automatic do_reset();
    i_status_valid = 1'b0;
    i_out_ready = 1'b0;
    i_rst_n = 1'b0;
    #1;
    i_rst_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(o_out_valid), 0);
    chk({tag, "_status"}, 32'(o_out_status), 0);
    chk({tag, "_rcnt"}, 32'(o_r_cnt), 0);
    chk({tag, "_icnt"}, 32'(o_i_cnt), 0);
    chk({tag, "_done"}, 32'(o_done), 0);
    chk({tag, "_cause"}, 32'(o_cause), 0);
    chk({tag, "_drop"}, 32'(o_drop), 0);
    chk({tag, "_cyc"}, 32'(o_cycle_cnt), 0);
  endtask

  logic [1:0] seq34 [5] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd3};
  logic [1:0] exp36 [4] = '{2'd1, 2'd0, 2'd1, 2'd1};
  int exp_cyc;

  initial begin
    #2;
    chk_all_zero("reset");
    @(posedge i_clk); #1;
    do_reset();

    // In-order streaming with immediate pop, terminated by EOF.
    i_out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      push(seq34[k]);
      chk($sformatf("t34_valid%0d", k), 32'(o_out_valid), 1);
      chk($sformatf("t34_head%0d", k), 32'(o_out_status), 32'(seq34[k]));
    end
    chk("t34_rcnt", 32'(o_r_cnt), 2);
    chk("t34_icnt", 32'(o_i_cnt), 2);
    chk("t34_cause", 32'(o_cause), 3);
    chk("t34_done_early", 32'(o_done), 0);
    cycle();
    chk("t34_done", 32'(o_done), 1);
    chk("t34_empty", 32'(o_out_valid), 0);
    chk("t34_empty_status", 32'(o_out_status), 0);

    // Overrun with no consumer.
    do_reset();
    for (int k = 0; k < 4; k++) push(2'(k % 2));
    chk("t35_nodrop4", 32'(o_drop), 0);
    push(2'd0);
    chk("t35_drop", 32'(o_drop), 1);
    chk("t35_rcnt", 32'(o_r_cnt), 3);
    chk("t35_icnt", 32'(o_i_cnt), 2);
    i_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t35_head%0d", k), 32'(o_out_status), 32'(k % 2));
      cycle();
    end
    chk("t35_empty", 32'(o_out_valid), 0);

    // Full FIFO, simultaneous push and pop.
    do_reset();
    for (int k = 0; k < 4; k++) push(2'(k % 2));
    i_out_ready = 1'b1;
    push(2'd1);
    i_out_ready = 1'b0;
    chk("t36_nodrop", 32'(o_drop), 0);
    chk("t36_icnt", 32'(o_i_cnt), 3);
    i_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t36_valid%0d", k), 32'(o_out_valid), 1);
      chk($sformatf("t36_head%0d", k), 32'(o_out_status), 32'(exp36[k]));
      cycle();
    end
    chk("t36_empty", 32'(o_out_valid), 0);

    // Overflow code stops acceptance; later inputs are ignored.
    do_reset();
    push(2'd2);
    push(2'd0);
    chk("t37_cause", 32'(o_cause), 2);
    chk("t37_rcnt", 32'(o_r_cnt), 0);
    chk("t37_head", 32'(o_out_status), 2);
    chk("t37_done_early", 32'(o_done), 0);
    i_out_ready = 1'b1;
    cycle();
    chk("t37_empty", 32'(o_out_valid), 0);
    chk("t37_done", 32'(o_done), 1);
    push(2'd1);
    chk("t37_ign_valid", 32'(o_out_valid), 0);
    chk("t37_ign_icnt", 32'(o_i_cnt), 0);
    chk("t37_ign_cause", 32'(o_cause), 2);
    chk("t37_hold_done", 32'(o_done), 1);

    // Reset mid-drain, then a fresh run.
    do_reset();
    push(2'd0);
    push(2'd1);
    push(2'd3);
    chk("t38_pre_valid", 32'(o_out_valid), 1);
    chk("t38_pre_cause", 32'(o_cause), 3);
    i_rst_n = 1'b0;
    #1;
    chk_all_zero("t38_rst");
    i_rst_n = 1'b1;
    i_out_ready = 1'b1;
    push(2'd1);
    chk("t38_head1", 32'(o_out_status), 1);
    push(2'd2);
    chk("t38_head2", 32'(o_out_status), 2);
    chk("t38_cause", 32'(o_cause), 2);
    cycle();
    chk("t38_done", 32'(o_done), 1);
    chk("t38_icnt", 32'(o_i_cnt), 1);

    // RUN cycle count: 10 idle edges, then EOF on the 11th.
    do_reset();
    for (int k = 0; k < 10; k++) cycle();
    push(2'd3);
`ifdef STATUS_MONITOR_CYCLE_CNT_EN
    exp_cyc = 11;
`else
    exp_cyc = 0;
`endif
    chk("t39_cyc", 32'(o_cycle_cnt), 32'(exp_cyc));
    i_out_ready = 1'b1;
    for (int k = 0; k < 5; k++) cycle();
    chk("t39_cyc_frozen", 32'(o_cycle_cnt), 32'(exp_cyc));
    chk("t39_done", 32'(o_done), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/status_monitor.md
STATUS_MONITOR -- requirements
Module: status_monitor

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set status FIFO entry count; it SHALL be a power of two and at least 2.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of every counter output.
REQ-003 i_clk  input  1  SHALL be the clock; all state SHALL update on its rising edge.
REQ-004 i_rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 i_status  input  2  SHALL carry the processor status code: 0=R-type, 1=I-type, 2=overflow, 3=end-of-file.
REQ-006 i_status_valid  input  1  SHALL qualify i_status for one cycle; there is no backpressure toward the processor.
REQ-007 o_out_status  output  2  SHALL present the FIFO head code.
REQ-008 o_out_valid  output  1  SHALL be high when the FIFO is non-empty.
REQ-009 i_out_ready  input  1  SHALL accept the head when high together with o_out_valid.
REQ-010 o_r_cnt, o_i_cnt  output  CNT_W  SHALL give the R-type and I-type status counts.
REQ-011 o_done  output  1  SHALL be the sticky run-complete flag.
REQ-012 o_cause  output  2  SHALL give the terminating code (2 or 3); it is 0 before termination.
REQ-013 o_drop  output  1  SHALL be the sticky FIFO-overrun flag.
REQ-014 o_cycle_cnt  output  CNT_W  SHALL give the cycles spent in RUN (see Configuration).

Function
REQ-015 The FSM SHALL have states RUN, DRAIN and DONE.
REQ-016 In RUN, i_status_valid=1 SHALL accept the code: push it to the FIFO and update counters.
REQ-017 Accepting code 2 or 3 SHALL latch o_cause and move to DRAIN on that edge.
REQ-018 In DRAIN and DONE, i_status_valid SHALL be ignored: no push, no count, no cause change.
REQ-019 DRAIN SHALL move to DONE on the edge where the FIFO is empty, or becomes empty by a pop.
REQ-020 o_done SHALL be high exactly when in DONE; DONE SHALL hold until reset.
REQ-021 Code 0 accepted SHALL increment o_r_cnt; code 1 accepted SHALL increment o_i_cnt; both counters SHALL saturate at all-ones.
REQ-022 The FIFO SHALL be first-word-fall-through: a code accepted at edge k is visible on o_out_status/o_out_valid in the cycle after edge k if the FIFO was empty.
REQ-023 A pop (o_out_valid & i_out_ready) SHALL advance the head; the pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 A push and a pop in the same cycle SHALL both occur, including when the FIFO is full; occupancy then stays unchanged and nothing is dropped.
REQ-025 A push into a full FIFO without a simultaneous pop SHALL discard the code and set o_drop; counters and cause latching SHALL still apply.
REQ-026 If a terminal code is dropped and the FIFO later empties, the DRAIN-to-DONE rule is unchanged.
REQ-027 i_out_ready while the FIFO is empty SHALL have no effect.
REQ-028 o_out_status SHALL be 0 while o_out_valid is low.

Reset
REQ-029 Asserting i_rst_n low SHALL, asynchronously and at any point including mid-drain, force state RUN and empty the FIFO.
REQ-030 Asserting i_rst_n low SHALL also force o_out_valid=0, o_out_status=0, all counters=0, o_done=0, o_cause=0 and o_drop=0.
REQ-031 The first code SHALL be accepted on the first rising edge after i_rst_n deasserts.

Configuration
REQ-032 With macro STATUS_MONITOR_CYCLE_CNT_EN defined, o_cycle_cnt SHALL increment on every edge while in RUN, including the edge leaving RUN, and saturate at all-ones; it SHALL freeze thereafter.
REQ-033 Without STATUS_MONITOR_CYCLE_CNT_EN, o_cycle_cnt SHALL be constant 0 and no counter register SHALL be built.

Verification
REQ-034 Push 0,1,1,0,3 on consecutive cycles, i_out_ready=1 -> the same codes appear in order, one cycle late; then o_r_cnt=2, o_i_cnt=2, o_cause=3, and o_done rises the cycle after 3 is popped.
REQ-035 i_out_ready=0 with FIFO_DEPTH=4, push 5 codes (0,1,0,1,0) -> o_drop=1, FIFO holds 0,1,0,1, o_r_cnt=3.
REQ-036 FIFO full, same-cycle push of 1 and pop -> o_drop stays 0 and occupancy stays 4.
REQ-037 Push 2, then push 0 the next cycle -> o_cause=2, o_r_cnt unchanged, FIFO contains only 2.
REQ-038 Assert i_rst_n low in DRAIN with 3 entries queued -> all outputs are 0 immediately, and a new run proceeds normally.
REQ-039 With STATUS_MONITOR_CYCLE_CNT_EN defined, 10 idle RUN cycles then code 3 on the 11th -> o_cycle_cnt=11 and stays frozen; without the macro -> o_cycle_cnt=0.
